// File: rtl/stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush,
// optional two-entry skid buffer and a saturating stall counter.
module stage_skid_reg #(
  parameter int unsigned             WIDTH         = 128,
  parameter bit                      SKID          = 1'b1,
  parameter logic [WIDTH-1:0]        RESET_PAYLOAD = '0,
  parameter int unsigned             CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] m, m_d;
  logic [WIDTH-1:0] s, s_d;
  logic             in_ready_q;
  logic             in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = m;
  // SKID=1 breaks the out_ready -> in_ready path; SKID=0 keeps it combinational.
  assign in_ready  = SKID ? in_ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state;
    m_d     = m;
    s_d     = s;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            m_d     = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            s_d     = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            m_d     = s;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      m          <= RESET_PAYLOAD;
      s          <= RESET_PAYLOAD;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_d;
      m          <= m_d;
      s          <= s_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stage_skid_reg.sv
// Directed bench: skid (a), no-skid (b) and 4-bit-counter (c) instances
// share one stimulus stream; each step checks the instance it targets.
module tb_stage_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        a_ir, a_ov;
  logic [7:0]  a_od;
  logic [15:0] a_sc;
  logic        b_ir, b_ov;
  logic [7:0]  b_od;
  logic [15:0] b_sc;
  logic        c_ir, c_ov;
  logic [7:0]  c_od;
  logic [3:0]  c_sc;

  int n_cmp = 0;
  int n_err = 0;

  stage_skid_reg #(.WIDTH(8), .SKID(1'b1), .RESET_PAYLOAD(8'hA5), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .stall_cnt(a_sc));

  stage_skid_reg #(.WIDTH(8), .SKID(1'b0), .RESET_PAYLOAD(8'hA5), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .stall_cnt(b_sc));

  stage_skid_reg #(.WIDTH(8), .SKID(1'b1), .RESET_PAYLOAD(8'h00), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_ir),
    .in_data(in_data), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .stall_cnt(c_sc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rst       = 1'b0;
    #2;
    rst       = 1'b1;
    tick();
  endtask

  initial begin
    // Reset held low with a valid input pending: nothing may be accepted
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    tick();
    tick();
    check("rst_ov",  32'(a_ov), 32'd0);
    check("rst_ir",  32'(a_ir), 32'd1);
    check("rst_sc",  32'(a_sc), 32'd0);
    check("rst_od",  32'(a_od), 32'hA5);
    check("rst_b_od", 32'(b_od), 32'hA5);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("rel_ov", 32'(a_ov), 32'd0);

    // Streaming with out_ready high
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    tick();
    check("str1_od", 32'(a_od), 32'h01);
    check("str1_ov", 32'(a_ov), 32'd1);
    check("str1_ir", 32'(a_ir), 32'd1);
    in_data = 8'h02;
    tick();
    check("str2_od", 32'(a_od), 32'h02);
    check("str2_ir", 32'(a_ir), 32'd1);
    in_data = 8'h03;
    tick();
    check("str3_od", 32'(a_od), 32'h03);
    check("str3_ir", 32'(a_ir), 32'd1);
    in_valid = 1'b0;
    tick();
    check("str_end_ov", 32'(a_ov), 32'd0);

    // Skid fill and drain
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h10;
    tick();
    check("skid_load_od", 32'(a_od), 32'h10);
    out_ready = 1'b0; in_data = 8'h11;
    tick();
    check("skid_full_ir", 32'(a_ir), 32'd0);
    check("skid_full_od", 32'(a_od), 32'h10);
    check("skid_full_ov", 32'(a_ov), 32'd1);
    in_valid = 1'b0;
    tick();
    check("skid_hold_od", 32'(a_od), 32'h10);
    check("skid_hold_ir", 32'(a_ir), 32'd0);
    out_ready = 1'b1;
    tick();
    check("skid_drain_od", 32'(a_od), 32'h11);
    check("skid_drain_ov", 32'(a_ov), 32'd1);
    check("skid_drain_ir", 32'(a_ir), 32'd1);
    tick();
    check("skid_empty_ov", 32'(a_ov), 32'd0);

    // SKID=0 combinational back-pressure
    do_reset();
    check("ns_empty_ir", 32'(b_ir), 32'd1);
    in_valid = 1'b1; in_data = 8'h20; out_ready = 1'b0;
    tick();
    check("ns_od", 32'(b_od), 32'h20);
    check("ns_ir_low", 32'(b_ir), 32'd0);
    in_data = 8'h21;
    #1;
    check("ns_ir_still_low", 32'(b_ir), 32'd0);
    out_ready = 1'b1;
    #1;
    check("ns_ir_comb", 32'(b_ir), 32'd1);
    tick();
    check("ns_next_od", 32'(b_od), 32'h21);
    check("ns_next_ov", 32'(b_ov), 32'd1);
    in_valid = 1'b0;
    tick();
    check("ns_empty_ov", 32'(b_ov), 32'd0);

    // Flush while FULL
    do_reset();
    in_valid = 1'b1; in_data = 8'h30; out_ready = 1'b0;
    tick();
    in_data = 8'h31;
    tick();
    check("fl_full_ir", 32'(a_ir), 32'd0);
    check("fl_pre_sc", 32'(a_sc), 32'd1);
    flush = 1'b1; in_data = 8'h32;
    tick();
    check("fl_ov", 32'(a_ov), 32'd0);
    check("fl_ir", 32'(a_ir), 32'd1);
    check("fl_sc", 32'(a_sc), 32'd2);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_after_ov", 32'(a_ov), 32'd0);
    in_valid = 1'b1; in_data = 8'h40;
    tick();
    check("fl_new_od", 32'(a_od), 32'h40);
    check("fl_new_ov", 32'(a_ov), 32'd1);
    in_valid = 1'b0;
    tick();
    check("fl_done_ov", 32'(a_ov), 32'd0);
    check("fl_done_sc", 32'(a_sc), 32'd2);

    // Stall counter saturation and async clear
    do_reset();
    in_valid = 1'b1; in_data = 8'h50; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("sat_start", 32'(c_sc), 32'd0);
    repeat (14) tick();
    check("sat_14", 32'(c_sc), 32'd14);
    repeat (6) tick();
    check("sat_hold", 32'(c_sc), 32'd15);
    check("sat_ov", 32'(c_ov), 32'd1);
    rst = 1'b0;
    #1;
    check("sat_async_sc", 32'(c_sc), 32'd0);
    check("sat_async_ov", 32'(c_ov), 32'd0);
    rst = 1'b1;
    tick();
    check("sat_post_sc", 32'(c_sc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage_skid_reg.md
# stage_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush, an optional two-entry skid buffer and a saturating stall counter. It sits between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the free-running per-stage registers. The stage payload (inst, pc, result, control) is packed by the caller into one `WIDTH`-bit vector. This lets a downstream stage apply back-pressure without losing data.

## Interface
- `WIDTH`, default 128: packed payload width in bits, must be ≥1.
- `SKID`, default 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- `RESET_PAYLOAD`, default `'0`: payload register value after reset.
- `CNT_W`, default 16: stall counter width.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserting it (low) clears state immediately; release is synchronised upstream.
- `flush`  in  1  synchronous pipeline flush (branch mispredict or exception).
- `in_valid`  in  1  upstream holds a valid payload.
- `in_ready`  out  1  this stage accepts a payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  payload presented downstream; always driven from the main register.
- `stall_cnt`  out  CNT_W  count of cycles with `out_valid && !out_ready`.

## Operation
- Handshake events: in_fire = `in_valid && in_ready`; out_fire = `out_valid && out_ready`.
- Storage: main register M; skid register S exists only when SKID=1.
- States: EMPTY, ONE (M valid), FULL (M and S valid; only reachable when SKID=1).
- Output decode: `out_valid` = (state != EMPTY); `out_data` = M.
- `in_ready`: SKID=1 gives a register equal to (next state != FULL). SKID=0 gives the combinational value `!out_valid || out_ready`.
- EMPTY + in_fire → ONE; M ← `in_data`.
- ONE + in_fire + out_fire → ONE; M ← `in_data`.
- ONE + in_fire + !out_fire → FULL with SKID=1 (S ← `in_data`). With SKID=0 this case cannot occur, because `in_ready` = 0.
- ONE + !in_fire + out_fire → EMPTY.
- FULL + out_fire → ONE; M ← S. No in_fire is possible in FULL because `in_ready` = 0.
- FULL + !out_fire → FULL; all registers hold.
- Ordering: strict FIFO; no payload is dropped or duplicated except by flush.
- Flush has the highest priority. The next state is EMPTY regardless of the other inputs.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle is a completed transfer.
  - M and S hold their contents; only validity is cleared.
- `stall_cnt`: +1 on every cycle with `out_valid && !out_ready`, including a flush cycle. It saturates at 2^CNT_W−1 and is cleared only by reset.
- Reset values: state EMPTY, `out_valid` = 0, `in_ready` = 1, M = S = `RESET_PAYLOAD`, `out_data` = `RESET_PAYLOAD`, `stall_cnt` = 0.

## Timing
- Latency: 1 cycle from in_fire to `out_valid` when the stage is empty.
- Throughput: 1 payload per cycle sustained in both modes while `out_ready` = 1.
- SKID=1: `in_ready` falls 1 cycle after the stall that filled S and rises 1 cycle after the out_fire that drained it. There is no combinational path from `out_ready` to `in_ready`.
- SKID=0: a combinational path from `out_ready` to `in_ready` exists by design.
- Back-pressure absorption: with SKID=1, an upstream that samples the registered `in_ready` loses no data when `out_ready` drops.
- Async reset mid-transfer: all state clears on the same cycle without waiting for `clk`. Inputs are ignored while `rst` = 0. The first in_fire is possible on the first rising edge after release.
- Flush: `out_valid` = 0 on the cycle after flush. With SKID=1, `in_ready` = 1 on that same cycle.

## Test plan
- Reset/idle: hold `rst` = 0 with `in_valid` = 1 and `in_data` = 0xAA → `out_valid` = 0, `in_ready` = 1, `stall_cnt` = 0, `out_data` = `RESET_PAYLOAD` throughout.
- Streaming (SKID=1, `out_ready` = 1): send 0x1, 0x2, 0x3 on consecutive cycles → `out_data` shows 0x1, 0x2, 0x3 on the next 3 cycles; `in_ready` stays 1.
- Skid fill/drain (SKID=1): load 0x10, drop `out_ready`, send 0x11.
  - Required: state FULL, `in_ready` = 0 the next cycle, and `out_data` = 0x10 held.
  - Then raise `out_ready`: outputs 0x10, then 0x11, then `out_valid` = 0, with no loss.
- SKID=0 back-pressure: with M = 0x20 and `out_ready` = 0 → `in_ready` = 0 in the same cycle; raising `out_ready` with `in_data` = 0x21 → `in_ready` = 1 combinationally, and 0x21 appears the next cycle.
- Flush in FULL: with M = 0x30, S = 0x31, assert `flush` with `in_valid` = 1, `in_data` = 0x32, `out_ready` = 0 → `out_valid` = 0 next cycle; none of 0x30, 0x31 or 0x32 is ever output; `stall_cnt` += 1.
- Counter saturation: CNT_W = 4, hold `out_valid` = 1 with `out_ready` = 0 for 20 cycles → `stall_cnt` reaches 15 and holds; async reset mid-stall → 0 immediately.
